// File: rtl/riscv_pkg.sv
// Shared RISC-V branch definitions for the fetch-path branch sequencer.
// Contents: branch funct3 encodings, sequencer state type, branch opcode and
// the sequential PC increment.
package riscv_pkg;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } branch_instr;

  typedef enum logic [1:0] {
    RUN,
    EVAL,
    FLUSH
  } br_state_t;

  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam int unsigned PC_STEP    = 4;

endpackage

// File: rtl/branch_cmp.sv
// Branch condition evaluator (purely combinational).
// Ports:
//   funct3  in   branch kind
//   rv1/rv2 in   operand values
//   taken   out  condition holds (0 for reserved encodings)
//   illegal out  funct3 is a reserved branch encoding (010/011)
module branch_cmp
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rv1,
  input  logic [XLEN-1:0] rv2,
  output logic            taken,
  output logic            illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      BEQ:     taken = (rv1 == rv2);
      BNE:     taken = (rv1 != rv2);
      BLT:     taken = ($signed(rv1) <  $signed(rv2));
      BGE:     taken = ($signed(rv1) >= $signed(rv2));
      BLTU:    taken = (rv1 <  rv2);
      BGEU:    taken = (rv1 >= rv2);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_seq_ctrl.sv
// Branch sequencer between decode and instruction fetch. Owns the fetch PC,
// accepts one instruction per in_valid/in_ready handshake, evaluates branches
// one cycle after acceptance and redirects + flushes fetch when taken.
// Optional build macro: BRANCH_PREDICT_EN (static backward-taken prediction).
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   in_valid/in_ready decode handshake
//   idata, iaddr, imm instruction word, its address, B-type offset
//   rv1, rv2          source operands
//   fetch_ready       fetch consumes pc this cycle
//   pc                next fetch address
//   flush             squash in-flight fetches
//   illegal, misalign, mispredict  one-cycle status pulses
module branch_seq_ctrl
  import riscv_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              FLUSH_CYCLES = 2,
  parameter logic [XLEN-1:0] RESET_PC     = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     idata,
  input  logic [XLEN-1:0] iaddr,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rv1,
  input  logic [XLEN-1:0] rv2,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] pc,
  output logic            flush,
  output logic            illegal,
  output logic            misalign,
  output logic            mispredict
);

  localparam logic [3:0]      FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);

  br_state_t       state_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] iaddr_q, imm_q, rv1_q, rv2_q, pc_q;
  logic [3:0]      cnt_q;
  logic            flush_q, illegal_q, misalign_q;

  logic            is_branch, cmp_taken, cmp_illegal, tgt_mis;
  logic [XLEN-1:0] target, seq_pc;

  // Only opcode and funct3 are decoded here.
  logic unused_idata;
  assign unused_idata = ^{idata[31:15], idata[11:7]};

  assign is_branch = (idata[6:0] == OPC_BRANCH);
  assign target    = iaddr_q + imm_q;
  assign seq_pc    = iaddr_q + STEP;
  assign tgt_mis   = (target[1:0] != 2'b00);

  // Evaluate from the captured operands only; decode may change inputs freely
  // once the branch has been accepted.
  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .funct3  (f3_q),
    .rv1     (rv1_q),
    .rv2     (rv2_q),
    .taken   (cmp_taken),
    .illegal (cmp_illegal)
  );

`ifdef BRANCH_PREDICT_EN
  logic pred_q, mispredict_q;
  assign mispredict = mispredict_q;
`else
  assign mispredict = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      f3_q       <= '0;
      iaddr_q    <= '0;
      imm_q      <= '0;
      rv1_q      <= '0;
      rv2_q      <= '0;
      cnt_q      <= '0;
      flush_q    <= 1'b0;
      illegal_q  <= 1'b0;
      misalign_q <= 1'b0;
`ifdef BRANCH_PREDICT_EN
      pred_q       <= 1'b0;
      mispredict_q <= 1'b0;
`endif
    end else begin
      illegal_q  <= 1'b0;
      misalign_q <= 1'b0;
`ifdef BRANCH_PREDICT_EN
      mispredict_q <= 1'b0;
`endif
      case (state_q)
        RUN: begin
          flush_q <= 1'b0;
          if (fetch_ready) pc_q <= pc_q + STEP;
          if (in_valid && is_branch) begin
            f3_q    <= idata[14:12];
            iaddr_q <= iaddr;
            imm_q   <= imm;
            rv1_q   <= rv1;
            rv2_q   <= rv2;
            state_q <= EVAL;
`ifdef BRANCH_PREDICT_EN
            // Backward branches are predicted taken at accept time.
            pred_q <= imm[XLEN-1];
            if (imm[XLEN-1]) begin
              pc_q    <= iaddr + imm;
              flush_q <= 1'b1;
            end
`endif
          end
        end
        EVAL: begin
          flush_q   <= 1'b0;
          state_q   <= RUN;
          illegal_q <= cmp_illegal;
`ifdef BRANCH_PREDICT_EN
          if (pred_q && tgt_mis) begin
            // Fetch went to a bad predicted target: undo it.
            misalign_q <= 1'b1;
            pc_q       <= seq_pc;
            flush_q    <= 1'b1;
            cnt_q      <= FLUSH_INIT;
            state_q    <= FLUSH;
          end else if (cmp_taken && tgt_mis) begin
            misalign_q <= 1'b1;
          end else if (pred_q != cmp_taken) begin
            mispredict_q <= 1'b1;
            pc_q         <= cmp_taken ? target : seq_pc;
            flush_q      <= 1'b1;
            cnt_q        <= FLUSH_INIT;
            state_q      <= FLUSH;
          end
`else
          if (cmp_taken && tgt_mis) begin
            // No redirect: pc keeps its current value.
            misalign_q <= 1'b1;
          end else if (cmp_taken) begin
            pc_q    <= target;
            flush_q <= 1'b1;
            cnt_q   <= FLUSH_INIT;
            state_q <= FLUSH;
          end else begin
            pc_q <= seq_pc;
          end
`endif
        end
        FLUSH: begin
          if (cnt_q == 4'd0) begin
            flush_q <= 1'b0;
            state_q <= RUN;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign in_ready = (state_q == RUN);
  assign pc       = pc_q;
  assign flush    = flush_q;
  assign illegal  = illegal_q;
  assign misalign = misalign_q;

endmodule
